// File: rtl/write_back_pkg.sv
// Shared widths, select encoding and control decode for the write-back stage.
package write_back_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_DOB_W  = 8;
  localparam int unsigned WB_RG_W   = 4;

  localparam logic SEL_ALU = 1'b0;
  localparam logic SEL_MEM = 1'b1;

  // Per-edge action on the output registers, listed in priority order.
  typedef enum logic [2:0] {
    WB_RESET  = 3'd0,
    WB_HOLD   = 3'd1,
    WB_KILL   = 3'd2,
    WB_LOAD   = 3'd3,
    WB_BUBBLE = 3'd4
  } wb_action_e;

  function automatic wb_action_e wb_decode(input logic rst, input logic stall,
                                           input logic flush, input logic in_valid);
    wb_action_e act;
    act = WB_BUBBLE;
    if (rst)           act = WB_RESET;
    else if (stall)    act = WB_HOLD;
    else if (flush)    act = WB_KILL;
    else if (in_valid) act = WB_LOAD;
    return act;
  endfunction

endpackage

// File: rtl/write_back_mux2.sv
// Parameterised 2:1 data select between ALU result and memory load data.
module wb_mux2
  import write_back_pkg::*;
#(
  parameter int unsigned W = WB_DATA_W
) (
  input  logic         sel,
  input  logic [W-1:0] in_alu,
  input  logic [W-1:0] in_mem,
  output logic [W-1:0] y_c
);

  assign y_c = (sel == SEL_MEM) ? in_mem : in_alu;

endmodule

// File: rtl/write_back.sv
// Write-back stage: selects ALU or load data and registers it with Rg, Dob and valid.
module write_back
  import write_back_pkg::*;
#(
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned DOB_W  = WB_DOB_W,
  parameter int unsigned RG_W   = WB_RG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Do,
  input  logic [DATA_W-1:0] ALU_Result,
  input  logic [DOB_W-1:0]  Dob_In,
  input  logic [RG_W-1:0]   Rg_In,
  input  logic              sel_dat,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  output logic [RG_W-1:0]   Rg,
  output logic [DATA_W-1:0] WriteBack_output,
  output logic [DOB_W-1:0]  Dob,
  output logic              out_valid
);

  logic [DATA_W-1:0] sel_data_c;
  wb_action_e        action_c;

  wb_mux2 #(.W(DATA_W)) u_mux (
    .sel    (sel_dat),
    .in_alu (ALU_Result),
    .in_mem (Do),
    .y_c    (sel_data_c)
  );

  assign action_c = wb_decode(rst, stall, flush, in_valid);

  // Data registers only move on reset or a live, unstalled, unflushed load.
  always_ff @(posedge clk) begin
    case (action_c)
      WB_RESET: begin
        Rg               <= '0;
        WriteBack_output <= '0;
        Dob              <= '0;
      end
      WB_LOAD: begin
        Rg               <= Rg_In;
        WriteBack_output <= sel_data_c;
        Dob              <= Dob_In;
      end
      default: ;
    endcase
  end

  // Valid doubles as the register-file write enable; stall keeps it as is.
  always_ff @(posedge clk) begin
    case (action_c)
      WB_RESET:  out_valid <= 1'b0;
      WB_HOLD:   out_valid <= out_valid;
      WB_KILL:   out_valid <= 1'b0;
      WB_LOAD:   out_valid <= 1'b1;
      WB_BUBBLE: out_valid <= 1'b0;
      default:   out_valid <= 1'b0;
    endcase
  end

endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back: select, truncation, stall/flush priority and reset.
module tb_write_back;
  import write_back_pkg::*;

  localparam int unsigned DATA_W = WB_DATA_W;
  localparam int unsigned DOB_W  = WB_DOB_W;
  localparam int unsigned RG_W   = WB_RG_W;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] Do;
  logic [DATA_W-1:0] ALU_Result;
  logic [DOB_W-1:0]  Dob_In;
  logic [RG_W-1:0]   Rg_In;
  logic              sel_dat;
  logic              in_valid;
  logic              stall;
  logic              flush;
  logic [RG_W-1:0]   Rg;
  logic [DATA_W-1:0] WriteBack_output;
  logic [DOB_W-1:0]  Dob;
  logic              out_valid;

  int n_vec;
  int n_miss;

  write_back #(.DATA_W(DATA_W), .DOB_W(DOB_W), .RG_W(RG_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .Do               (Do),
    .ALU_Result       (ALU_Result),
    .Dob_In           (Dob_In),
    .Rg_In            (Rg_In),
    .sel_dat          (sel_dat),
    .in_valid         (in_valid),
    .stall            (stall),
    .flush            (flush),
    .Rg               (Rg),
    .WriteBack_output (WriteBack_output),
    .Dob              (Dob),
    .out_valid        (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] a,
                       input logic [DOB_W-1:0] b, input logic [RG_W-1:0] r,
                       input logic s, input logic v);
    Do = d; ALU_Result = a; Dob_In = b; Rg_In = r; sel_dat = s; in_valid = v;
  endtask

  task automatic expect_all(input string tag, input logic [DATA_W-1:0] wb,
                            input logic [DOB_W-1:0] b, input logic [RG_W-1:0] r,
                            input logic v);
    check({tag, ".wb"},    32'(WriteBack_output), 32'(wb));
    check({tag, ".dob"},   32'(Dob),              32'(b));
    check({tag, ".rg"},    32'(Rg),               32'(r));
    check({tag, ".valid"}, 32'(out_valid),        32'(v));
  endtask

  initial begin
    logic [7:0] rg_wide;
    n_vec = 0;
    n_miss = 0;
    stall = 1'b0;
    flush = 1'b0;

    // Reset with random inputs, including a live instruction.
    rst = 1'b1;
    drive($urandom, $urandom, DOB_W'($urandom), RG_W'($urandom), 1'($urandom), 1'b1);
    tick();
    drive($urandom, $urandom, DOB_W'($urandom), RG_W'($urandom), 1'($urandom), 1'b1);
    tick();
    expect_all("reset", '0, '0, '0, 1'b0);

    rst = 1'b0;
    drive(32'hEA4, 32'h1245, 8'd3, 4'd4, SEL_ALU, 1'b1);
    tick();
    expect_all("alu_sel", 32'h1245, 8'd3, 4'd4, 1'b1);

    sel_dat = SEL_MEM;
    tick();
    expect_all("mem_sel", 32'hEA4, 8'd3, 4'd4, 1'b1);

    // Rg_In driven from an 8-bit value; only the low nibble reaches the port.
    rg_wide = 8'h58;
    drive(32'hBBB, 32'h555, 8'd69, rg_wide[RG_W-1:0], SEL_ALU, 1'b1);
    tick();
    expect_all("trunc_alu", 32'h555, 8'd69, 4'd8, 1'b1);

    sel_dat = SEL_MEM;
    tick();
    check("trunc_mem.wb", 32'(WriteBack_output), 32'hBBB);

    // Stall holds everything despite new inputs.
    stall = 1'b1;
    drive(32'h1111, 32'h2222, 8'h07, 4'd1, SEL_ALU, 1'b1);
    tick();
    expect_all("stall", 32'hBBB, 8'd69, 4'd8, 1'b1);

    flush = 1'b1;
    tick();
    expect_all("stall_flush", 32'hBBB, 8'd69, 4'd8, 1'b1);

    stall = 1'b0;
    tick();
    expect_all("flush", 32'hBBB, 8'd69, 4'd8, 1'b0);

    flush = 1'b0;
    tick();
    expect_all("reload", 32'h2222, 8'h07, 4'd1, 1'b1);

    drive(32'h3333, 32'h4444, 8'hAA, 4'd9, SEL_MEM, 1'b0);
    tick();
    expect_all("bubble", 32'h2222, 8'h07, 4'd1, 1'b0);

    // Back-to-back throughput, extreme values.
    drive(32'hFFFF_FFFF, 32'h0, 8'hFF, 4'hF, SEL_MEM, 1'b1);
    tick();
    expect_all("b2b_0", 32'hFFFF_FFFF, 8'hFF, 4'hF, 1'b1);
    drive(32'h0, 32'h8000_0001, 8'h80, 4'h2, SEL_ALU, 1'b1);
    tick();
    expect_all("b2b_1", 32'h8000_0001, 8'h80, 4'h2, 1'b1);

    // Reset wins over stall and a live input.
    rst = 1'b1;
    stall = 1'b1;
    tick();
    expect_all("rst_stall", '0, '0, '0, 1'b0);

    rst = 1'b0;
    stall = 1'b0;
    in_valid = 1'b0;
    tick();
    expect_all("post_rst", '0, '0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
